// File: rtl/jpeg_bit_packer.sv
// Packs variable-length entropy codes MSB-first into a byte-stuffed JPEG scan byte stream.
// Optional EOI marker (0xFF,0xD9) after each frame when JPEG_EOI_EN is defined.
module jpeg_bit_packer #(
    parameter int CODE_W = 27,
    parameter int ACC_W  = 48,
    parameter int LEN_W  = $clog2(CODE_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic [CODE_W-1:0] code_bits,
    input  logic [LEN_W-1:0]  code_len,
    input  logic              code_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last
);

`ifdef JPEG_EOI_EN
    localparam bit EOI_EN = 1'b1;
`else
    localparam bit EOI_EN = 1'b0;
`endif

    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(ACC_W - CODE_W);

    typedef enum logic [2:0] {RUN, STUFF, FLUSH, EOI_FF, EOI_D9} state_t;

    state_t             state, state_n;
    logic               ret_flush, ret_flush_n;
    logic [ACC_W-1:0]   acc, acc_n, acc_p, code_ext;
    logic [FILL_W-1:0]  fill, fill_n, fill_p, shamt, left_f;
    logic [CODE_W-1:0]  code_mask;
    logic [LEN_W-1:0]   len_eff;
    logic [7:0]         top, byte_f;
    logic               free, accept, pop;
    logic               out_valid_n, out_last_n;
    logic [7:0]         out_data_n;

    assign code_ready = (state == RUN) && (fill <= FILL_MAX) && !rst;

    // Bits live MSB-aligned in acc; everything below the fill point stays zero.
    always_comb begin
        free      = !out_valid || out_ready;
        accept    = code_valid && code_ready;
        len_eff   = (code_len > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : code_len;
        code_mask = (CODE_W'(1) << len_eff) - CODE_W'(1);
        code_ext  = ACC_W'(code_bits & code_mask);
        top       = acc[ACC_W-1 -: 8];
        // Hold back at least one bit while running so the final byte is always emitted by FLUSH.
        pop       = (state == RUN) && free && (fill > FILL_W'(8));
        acc_p     = pop ? (acc << 8) : acc;
        fill_p    = pop ? (fill - FILL_W'(8)) : fill;
        shamt     = FILL_W'(ACC_W) - fill_p - FILL_W'(len_eff);
        left_f    = (fill >= FILL_W'(8)) ? (fill - FILL_W'(8)) : '0;
        byte_f    = (fill >= FILL_W'(8)) ? top : (top | (8'hFF >> fill));
    end

    always_comb begin
        state_n     = state;
        ret_flush_n = ret_flush;
        acc_n       = acc_p;
        fill_n      = fill_p;
        out_valid_n = out_valid && !out_ready;
        out_data_n  = out_data;
        out_last_n  = out_last;
        if (accept) begin
            acc_n  = acc_p | (code_ext << shamt);
            fill_n = fill_p + FILL_W'(len_eff);
        end
        case (state)
            RUN: begin
                if (pop) begin
                    out_valid_n = 1'b1;
                    out_data_n  = top;
                    out_last_n  = 1'b0;
                end
                if (pop && top == 8'hFF) begin
                    state_n     = STUFF;
                    ret_flush_n = accept && code_last;
                end else if (accept && code_last) begin
                    state_n = FLUSH;
                end
            end
            STUFF: begin
                if (free) begin
                    out_valid_n = 1'b1;
                    out_data_n  = 8'h00;
                    out_last_n  = ret_flush && (fill == '0) && !EOI_EN;
                    state_n     = ret_flush ? FLUSH : RUN;
                    ret_flush_n = 1'b0;
                end
            end
            FLUSH: begin
                if (free) begin
                    if (fill == '0) begin
                        state_n = EOI_EN ? EOI_FF : RUN;
                    end else begin
                        out_valid_n = 1'b1;
                        out_data_n  = byte_f;
                        out_last_n  = (byte_f != 8'hFF) && (left_f == '0) && !EOI_EN;
                        acc_n       = acc << 8;
                        fill_n      = left_f;
                        if (byte_f == 8'hFF) begin
                            state_n     = STUFF;
                            ret_flush_n = 1'b1;
                        end else if (left_f == '0) begin
                            state_n = EOI_EN ? EOI_FF : RUN;
                        end
                    end
                end
            end
            EOI_FF: begin
                if (free) begin
                    out_valid_n = 1'b1;
                    out_data_n  = 8'hFF;
                    out_last_n  = 1'b0;
                    state_n     = EOI_D9;
                end
            end
            EOI_D9: begin
                if (free) begin
                    out_valid_n = 1'b1;
                    out_data_n  = 8'hD9;
                    out_last_n  = 1'b1;
                    state_n     = RUN;
                end
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            ret_flush <= 1'b0;
            acc       <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
        end else begin
            state     <= state_n;
            ret_flush <= ret_flush_n;
            acc       <= acc_n;
            fill      <= fill_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_last  <= out_last_n;
        end
    end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Randomized self-checking bench for jpeg_bit_packer against a bit-queue reference model.
module tb_jpeg_bit_packer;
    localparam int CODE_W = 27;
    localparam int ACC_W  = 48;
    localparam int LEN_W  = 5;
`ifdef JPEG_EOI_EN
    localparam bit EOI = 1'b1;
`else
    localparam bit EOI = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              code_valid;
    logic              code_ready;
    logic [CODE_W-1:0] code_bits;
    logic [LEN_W-1:0]  code_len;
    logic              code_last;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_last;

    jpeg_bit_packer #(.CODE_W(CODE_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .code_valid(code_valid), .code_ready(code_ready), .code_bits(code_bits),
        .code_len(code_len), .code_last(code_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;
    logic [8:0] exp_q[$];
    logic [8:0] fb[$];
    logic [CODE_W-1:0] fc_bits[$];
    int fc_len[$];
    bit hold_v = 1'b0;
    logic [8:0] hold_d;
    bit saw_ready_low;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Output side: every transfer is compared, stalled outputs must hold.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'({out_last, out_data}), 32'(hold_d));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got %0h with no byte expected", {out_last, out_data});
                end else begin
                    e = exp_q.pop_front();
                    chk("byte", 32'({out_last, out_data}), 32'(e));
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = {out_last, out_data};
            if (code_valid && !code_ready) saw_ready_low = 1'b1;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Reference: concatenate, pad with ones, split into bytes, stuff after 0xFF, mark last.
    task automatic build_frame();
        bit bits[$];
        logic [CODE_W-1:0] cb;
        logic [7:0] b;
        int l;
        fb.delete();
        for (int k = 0; k < fc_bits.size(); k++) begin
            cb = fc_bits[k];
            l = (fc_len[k] > CODE_W) ? CODE_W : fc_len[k];
            for (int i = l - 1; i >= 0; i--) bits.push_back(cb[i]);
        end
        if (bits.size() > 0)
            while (bits.size() % 8 != 0) bits.push_back(1'b1);
        for (int i = 0; i < bits.size(); i += 8) begin
            b = 8'h00;
            for (int j = 0; j < 8; j++) b = {b[6:0], bits[i + j]};
            fb.push_back({1'b0, b});
            if (b == 8'hFF) fb.push_back(9'h000);
        end
`ifdef JPEG_EOI_EN
        fb.push_back({1'b0, 8'hFF});
        fb.push_back({1'b1, 8'hD9});
`else
        if (fb.size() > 0) fb[fb.size() - 1][8] = 1'b1;
`endif
        foreach (fb[i]) exp_q.push_back(fb[i]);
    endtask

    task automatic pin(input string name, input int n, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2);
        logic [8:0] r[$];
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? d0 : (i == 1) ? d1 : d2;
            r.push_back({(i == n - 1) && !EOI, d});
        end
        if (EOI) begin
            r.push_back({1'b0, 8'hFF});
            r.push_back({1'b1, 8'hD9});
        end
        chk({name, "_size"}, 32'(fb.size()), 32'(r.size()));
        for (int i = 0; i < r.size() && i < fb.size(); i++) chk(name, 32'(fb[i]), 32'(r[i]));
    endtask

    task automatic send_code(input logic [CODE_W-1:0] b, input int l, input bit last);
        bit accepted = 1'b0;
        code_bits  = b;
        code_len   = LEN_W'(l);
        code_last  = last;
        code_valid = 1'b1;
        for (int t = 0; t < 1000 && !accepted; t++) begin
            @(negedge clk);
            if (code_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL code_accept_timeout: got no accept expected accept within 1000 cycles");
        end
    endtask

    task automatic send_frame(input bit gaps);
        for (int k = 0; k < fc_bits.size(); k++) begin
            send_code(fc_bits[k], fc_len[k], k == fc_bits.size() - 1);
            if (gaps && $urandom_range(0, 3) == 0) begin
                code_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        code_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge clk);
        chk(name, 32'(exp_q.size()), 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [CODE_W-1:0] b, input int l);
        fc_bits.push_back(b);
        fc_len.push_back(l);
    endtask

    task automatic new_frame();
        fc_bits.delete();
        fc_len.delete();
    endtask

    initial begin
        int n;
        int r;
        int l;
        int n55;
        rst = 1'b1;
        code_valid = 1'b0;
        code_bits = '0;
        code_len = '0;
        code_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_code_ready", 32'(code_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        new_frame(); add(27'hAA, 8); build_frame(); pin("pin_single", 1, 8'hAA, 8'h00, 8'h00);
        send_frame(1'b0); wait_drain("drain_single");
        @(negedge clk); chk("ready_after_frame", 32'(code_ready), 32'd1);
        @(posedge clk); #1;

        new_frame(); add(27'hFF, 8); add(27'h12, 8); build_frame();
        pin("pin_stuff", 3, 8'hFF, 8'h00, 8'h12);
        send_frame(1'b0); wait_drain("drain_stuff");

        new_frame(); add(27'b101, 3); build_frame(); pin("pin_pad", 1, 8'hBF, 8'h00, 8'h00);
        send_frame(1'b0); wait_drain("drain_pad");

        new_frame(); add(27'h7F, 7); build_frame(); pin("pin_pad_ff", 2, 8'hFF, 8'h00, 8'h00);
        send_frame(1'b0); wait_drain("drain_pad_ff");

        new_frame(); add(27'hAB, 8); add(27'h5, 0); build_frame(); pin("pin_len0_last", 1, 8'hAB, 8'h00, 8'h00);
        send_frame(1'b0); wait_drain("drain_len0_last");

        new_frame(); add(27'h3, 0); build_frame(); pin("pin_empty", 0, 8'h00, 8'h00, 8'h00);
        send_frame(1'b0); wait_drain("drain_empty");

        // Backpressure: 80 two-bit codes against a stalled output
        new_frame();
        for (int i = 0; i < 80; i++) add(27'b01, 2);
        build_frame();
        n55 = 0;
        for (int i = 0; i < 20 && i < fb.size(); i++) if (fb[i][7:0] == 8'h55) n55++;
        chk("pin_bp_count", 32'(n55), 32'd20);
        chk("pin_bp_size", 32'(fb.size()), EOI ? 32'd22 : 32'd20);
        saw_ready_low = 1'b0;
        ready_mode = 2;
        @(posedge clk); #1;
        fork
            send_frame(1'b0);
            begin
                repeat (30) @(posedge clk);
                #1;
                ready_mode = 0;
            end
        join
        chk("bp_ready_dropped", 32'(saw_ready_low), 32'd1);
        wait_drain("drain_bp");

        // Reset in the middle of a frame with 13 bits pending
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_code(27'h1FFF, 13, 1'b0);
        code_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_data", 32'(out_data), 32'd0);
        chk("post_rst_last", 32'(out_last), 32'd0);
        @(posedge clk); #1;
        ready_mode = 0;
        new_frame(); add(27'hC3, 8); build_frame(); pin("pin_after_rst", 1, 8'hC3, 8'h00, 8'h00);
        send_frame(1'b0); wait_drain("drain_after_rst");

        // Random frames with random downstream stalls
        ready_mode = 1;
        for (int f = 0; f < 200; f++) begin
            new_frame();
            n = $urandom_range(1, 7);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 9);
                if (r == 0) l = 0;
                else if (r == 1) l = $urandom_range(28, 31);
                else l = $urandom_range(1, 27);
                add(CODE_W'($urandom), l);
            end
            build_frame();
            send_frame(1'b1);
        end
        ready_mode = 0;
        wait_drain("drain_random");
        repeat (10) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
